// File: rtl/i8088_bus_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i8088_bus_pkg
// Shared types and constants for the minimum-mode 8088 bus initiator.
//   bus_state_t : T-state encoding of the bus cycle sequencer.
//   bus_req_t   : host request latched at accept time.
//   IDLE_*      : strobe levels driven whenever no bus cycle is running.
//   upper_addr  : A[19:8] for a request (A[19:16] zeroed on I/O cycles).
// ---------------------------------------------------------------------------
package i8088_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } bus_state_t;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  localparam logic        IDLE_ALE = 1'b0;
  localparam logic        IDLE_RD  = 1'b1;
  localparam logic        IDLE_WR  = 1'b1;
  localparam logic        IDLE_DEN = 1'b1;
  localparam logic        IDLE_DTR = 1'b1;
  localparam logic        IDLE_IOM = 1'b0;
  localparam logic [11:0] IDLE_A   = 12'h000;

  // I/O space is only 64K on the 8088, so the top nibble is driven low.
  function automatic logic [11:0] upper_addr(input bus_req_t req);
    return req.io ? {4'h0, req.addr[15:8]} : req.addr[19:8];
  endfunction

endpackage

// File: rtl/i8088_bus_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i8088_bus_master
// Minimum-mode 8088 bus initiator: each accepted single-byte host request
// becomes one T1-T2-T3-(TW)*-T4 bus cycle on the multiplexed 8088 pin bus.
//
// Optional feature macro: I8088_BUS_TIMEOUT_EN
//   defined   : TW states are counted; READY still low at the end of the
//               MAX_WAIT-th TW aborts to T4 with rsp_err=1.
//   undefined : waits forever on READY; rsp_err is constant 0.
//
// Ports
//   CLK, RESET            bus clock (posedge), asynchronous active-high reset
//   req_valid/req_ready   host request handshake (ready only in IDLE)
//   req_write, req_io     cycle type (write/read, I/O/memory)
//   req_addr[19:0]        byte address
//   req_wdata[7:0]        write data
//   rsp_valid             one-cycle completion pulse in T4
//   rsp_rdata[7:0]        last read byte (held until the next read)
//   rsp_err               with rsp_valid: cycle aborted by wait timeout
//   READY                 responder ready, sampled at the end of T3/TW
//   AD[7:0]               multiplexed address/data, released when idle
//   A[11:0]               address bits 19:8
//   ALE, RD, WR, IOM, DTR, DEN  bus strobes (RD/WR/DEN active-low)
// ---------------------------------------------------------------------------
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  inout  tri   [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic        DTR,
  output logic        DEN
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..255");
  end

  bus_state_t r_state;
  bus_state_t w_next_state;
  bus_req_t   r_req;
  logic [7:0] r_rdata;
  logic       w_data_phase;
  logic       w_timeout;
  logic       w_ad_oe;
  logic [7:0] w_ad_out;

  // T3 and TW are the only states whose closing edge looks at READY.
  assign w_data_phase = (r_state == S_T3) || (r_state == S_TW);

`ifdef I8088_BUS_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_err;

  // r_wait_cnt holds the number of TW states already completed, so the
  // current TW is number r_wait_cnt+1.
  assign w_timeout = (r_state == S_TW) && !READY &&
                     (r_wait_cnt == 8'(MAX_WAIT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait_cnt <= 8'h00;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_T3) begin
        r_wait_cnt <= 8'h00;
      end else if (r_state == S_TW) begin
        r_wait_cnt <= r_wait_cnt + 8'h01;
      end
      // Sampled on the edge that leaves T3/TW; held through T4.
      if (w_data_phase) begin
        r_err <= w_timeout;
      end
    end
  end

  assign rsp_err = (r_state == S_T4) && r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next_state = S_T1;
      S_T1:    w_next_state = S_T2;
      S_T2:    w_next_state = S_T3;
      S_T3:    w_next_state = READY ? S_T4 : S_TW;
      S_TW:    if (READY || w_timeout) w_next_state = S_T4;
      S_T4:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && req_valid) begin
        r_req <= '{write: req_write, io: req_io, addr: req_addr, wdata: req_wdata};
      end
      if (w_data_phase && READY && !r_req.write) begin
        r_rdata <= AD;
      end
    end
  end

  // Moore output decode: everything depends on r_state/r_req only.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !RESET;
    rsp_valid = 1'b0;
    ALE       = IDLE_ALE;
    RD        = IDLE_RD;
    WR        = IDLE_WR;
    DEN       = IDLE_DEN;
    DTR       = IDLE_DTR;
    IOM       = IDLE_IOM;
    A         = IDLE_A;
    w_ad_oe   = 1'b0;
    w_ad_out  = r_req.addr[7:0];
    case (r_state)
      S_T1: begin
        ALE     = 1'b1;
        A       = upper_addr(r_req);
        IOM     = r_req.io;
        DTR     = r_req.write;
        w_ad_oe = 1'b1;
      end
      S_T2, S_T3, S_TW: begin
        A        = upper_addr(r_req);
        IOM      = r_req.io;
        DTR      = r_req.write;
        RD       = r_req.write;
        WR       = !r_req.write;
        DEN      = 1'b0;
        w_ad_oe  = r_req.write;
        w_ad_out = r_req.wdata;
      end
      S_T4: begin
        A         = upper_addr(r_req);
        IOM       = r_req.io;
        DTR       = r_req.write;
        rsp_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign AD        = w_ad_oe ? w_ad_out : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_i8088_bus_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i8088_bus_master
// Directed bench for i8088_bus_master. A cycle-indexed table of expected pin
// values is filled per transaction from the bus-cycle rules and compared
// against the DUT on every falling edge. A small byte-memory responder sits
// on the bus; a separate reference memory supplies expected read data.
// Build with I8088_BUS_TIMEOUT_EN defined to exercise the timeout abort.
// ---------------------------------------------------------------------------
module tb_i8088_bus_master;

`ifdef I8088_BUS_TIMEOUT_EN
  localparam int MW   = 4;
  localparam int HOLD = 2;
`else
  localparam int MW   = 15;
  localparam int HOLD = 1000;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        READY = 1'b1;
  wire  [7:0]  ad_bus;
  logic [11:0] A;
  logic        ALE, RD, WR, IOM, DTR, DEN;

  logic        resp_oe;
  logic [7:0]  resp_data = 8'h00;

  always #5 CLK = ~CLK;

  i8088_bus_master #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(READY), .AD(ad_bus), .A(A),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN)
  );

  // ---------------- responder ----------------
  logic [7:0]  resp_mem [int];
  logic [7:0]  resp_io  [int];
  logic [19:0] lat_addr = 20'h0;
  logic        lat_io   = 1'b0;

  assign resp_oe = !RD && !RESET;
  assign ad_bus  = resp_oe ? resp_data : 8'bzzzz_zzzz;

  always @(negedge CLK) begin
    if (ALE) begin
      lat_addr = {A, ad_bus};
      lat_io   = IOM;
    end
    if (!RD) begin
      if (lat_io) resp_data = resp_io.exists(int'(lat_addr[15:0])) ? resp_io[int'(lat_addr[15:0])] : 8'hFF;
      else        resp_data = resp_mem.exists(int'(lat_addr)) ? resp_mem[int'(lat_addr)] : 8'hFF;
    end
  end

  always @(posedge CLK) begin
    if (!WR && !RESET) begin
      if (lat_io) resp_io[int'(lat_addr[15:0])] = ad_bus;
      else        resp_mem[int'(lat_addr)]      = ad_bus;
    end
  end

  // ---------------- model ----------------
  typedef struct {
    bit        ale, rd, wr, den, dtr, iom, oe, rv, err, rr;
    bit [11:0] a;
    bit [7:0]  ad, rdata;
  } exp_t;

  exp_t       exp_tab [int];
  bit         low_tab [int];
  logic [7:0] ref_mem [int];
  logic [7:0] ref_io  [int];
  logic [7:0] last_rdata = 8'h00;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int rd_cnt = 0;
  int rv_cycles[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // READY for the edge that ends cycle cyc.
  always @(negedge CLK) READY = !low_tab.exists(cyc);

  function automatic exp_t idle_exp();
    exp_t e;
    e.ale = 0; e.rd = 1; e.wr = 1; e.den = 1; e.dtr = 1; e.iom = 0;
    e.oe = 0; e.rv = 0; e.err = 0; e.rr = 1; e.a = 12'h0; e.ad = 8'h0;
    e.rdata = 8'h0;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  // Expected pins for one transaction whose T1 is cycle t, with n TW states.
  // tmo: READY never rises and the cycle is expected to abort after n TWs.
  task automatic plan(input int t, input bit w, input bit io, input bit [19:0] addr,
                      input bit [7:0] wd, input int n, input bit tmo);
    exp_t e;
    int   lows;
    e = idle_exp();
    e.rr  = 0;
    e.dtr = w;
    e.iom = io;
    e.a   = io ? {4'h0, addr[15:8]} : addr[19:8];
    e.ale = 1; e.oe = 1; e.ad = addr[7:0];
    exp_tab[t] = e;
    e.ale = 0; e.rd = w; e.wr = !w; e.den = 0; e.oe = w; e.ad = wd;
    for (int i = 1; i <= 2 + n; i++) exp_tab[t + i] = e;
    lows = tmo ? n + 1 : n;
    for (int i = 0; i < lows; i++) low_tab[t + 2 + i] = 1'b1;
    if (w) begin
      if (io) ref_io[int'(addr[15:0])] = wd;
      else    ref_mem[int'(addr)]      = wd;
    end else if (!tmo) begin
      if (io) last_rdata = ref_io.exists(int'(addr[15:0])) ? ref_io[int'(addr[15:0])] : 8'hFF;
      else    last_rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'hFF;
    end
    e.rd = 1; e.wr = 1; e.den = 1; e.oe = 0; e.rv = 1; e.err = tmo;
    e.rdata = last_rdata;
    exp_tab[t + 3 + n] = e;
  endtask

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    exp_t e;
    if (chk_en) begin
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : idle_exp();
      check("ALE", ALE, e.ale);
      check("RD", RD, e.rd);
      check("WR", WR, e.wr);
      check("DEN", DEN, e.den);
      check("DTR", DTR, e.dtr);
      check("IOM", IOM, e.iom);
      check("A", A, e.a);
      check("AD_drive", dut.w_ad_oe, e.oe);
      check("req_ready", req_ready, e.rr);
      check("rsp_valid", rsp_valid, e.rv);
      check("rsp_err", rsp_err, e.err);
      if (e.oe) check("AD", ad_bus, e.ad);
      if (e.rv) check("rsp_rdata", rsp_rdata, e.rdata);
      if (rsp_valid) rv_cycles.push_back(cyc);
      if (!RD) rd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input bit w, input bit io, input bit [19:0] addr,
                     input bit [7:0] wd, input int n, input bit tmo);
    int t;
    @(negedge CLK);
    req_write = w; req_io = io; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge CLK);
    #1;
    t = cyc;
    plan(t, w, io, addr, wd, n, tmo);
    req_valid = 1'b0;
    $display("txn %s %s addr=%05h wdata=%02h waits=%0d T1=cycle %0d",
             w ? "write" : "read ", io ? "io " : "mem", addr, wd, n, t);
    repeat (n + 4) @(posedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit [19:0] b_addr [4];
    bit [7:0]  b_wd   [4];
    bit        b_w    [4];

    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = 20'h0; req_wdata = 8'h0;
    resp_mem[int'(20'h80010)] = 8'h5A;
    ref_mem[int'(20'h80010)]  = 8'h5A;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("reset ALE", ALE, 1'b0);
    check("reset RD", RD, 1'b1);
    check("reset WR", WR, 1'b1);
    check("reset DEN", DEN, 1'b1);
    check("reset DTR", DTR, 1'b1);
    check("reset IOM", IOM, 1'b0);
    check("reset A", A, 12'h000);
    check("reset req_ready", req_ready, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_rdata", rsp_rdata, 8'h00);
    RESET = 1'b0;
    #1;
    chk_en = 1'b1;

    // Memory write
    txn(1'b1, 1'b0, 20'h12345, 8'hA5, 0, 1'b0);
    check("m1 stored byte", resp_mem.exists(int'(20'h12345)) ? resp_mem[int'(20'h12345)] : 8'h00, 8'hA5);

    // Memory read with 3 wait states
    rd_cnt = 0;
    txn(1'b0, 1'b0, 20'h80010, 8'h00, 3, 1'b0);
    check("RD low cycles", rd_cnt, 5);
    check("read 80010 data", rsp_rdata, 8'h5A);

    // I/O write then I/O read back
    txn(1'b1, 1'b1, 20'hF01C0, 8'h3C, 0, 1'b0);
    txn(1'b0, 1'b1, 20'hF01C0, 8'h00, 1, 1'b0);
    check("io readback", rsp_rdata, 8'h3C);

    // Memory read-back of the first write
    txn(1'b0, 1'b0, 20'h12345, 8'h00, 0, 1'b0);
    check("mem readback", rsp_rdata, 8'hA5);

    // Back-to-back with req_valid held high
    b_w[0] = 1'b1; b_addr[0] = 20'h00100; b_wd[0] = 8'h11;
    b_w[1] = 1'b0; b_addr[1] = 20'h00100; b_wd[1] = 8'h00;
    b_w[2] = 1'b1; b_addr[2] = 20'h0FFFF; b_wd[2] = 8'hEE;
    b_w[3] = 1'b0; b_addr[3] = 20'h80010; b_wd[3] = 8'h00;
    rv_cycles.delete();
    @(negedge CLK);
    req_write = b_w[0]; req_io = 1'b0; req_addr = b_addr[0]; req_wdata = b_wd[0];
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      t = cyc;
      plan(t, b_w[k], 1'b0, b_addr[k], b_wd[k], 0, 1'b0);
      $display("txn b2b %s addr=%05h wdata=%02h T1=cycle %0d",
               b_w[k] ? "write" : "read ", b_addr[k], b_wd[k], t);
      if (k < 3) begin
        req_write = b_w[k+1]; req_addr = b_addr[k+1]; req_wdata = b_wd[k+1];
      end else begin
        req_valid = 1'b0;
      end
      repeat (4) @(posedge CLK);
    end
    @(negedge CLK);
    check("b2b pulse count", rv_cycles.size(), 4);
    if (rv_cycles.size() == 4) begin
      for (int k = 1; k < 4; k++) check("b2b spacing", rv_cycles[k] - rv_cycles[k-1], 5);
    end
    check("b2b last read", rsp_rdata, 8'h5A);

`ifdef I8088_BUS_TIMEOUT_EN
    // READY never rises: abort after MW wait states
    rd_cnt = 0;
    txn(1'b0, 1'b0, 20'h80010, 8'h00, MW, 1'b1);
    check("timeout RD low cycles", rd_cnt, 2 + MW);
    check("timeout keeps rdata", rsp_rdata, 8'h5A);
`endif

    // Reset in the middle of a wait-stated read
    @(negedge CLK);
    req_write = 1'b0; req_io = 1'b0; req_addr = 20'h80010; req_wdata = 8'h00;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    t = cyc;
    plan(t, 1'b0, 1'b0, 20'h80010, 8'h00, HOLD + 3, 1'b0);
    req_valid = 1'b0;
    $display("txn read  mem addr=80010 held in TW for %0d cycles then reset, T1=cycle %0d", HOLD, t);
    repeat (3 + HOLD) @(posedge CLK);
    #2;
    check("RD still low in TW", RD, 1'b0);
    chk_en = 1'b0;
    RESET = 1'b1;
    #1;
    check("rst RD", RD, 1'b1);
    check("rst DEN", DEN, 1'b1);
    check("rst AD released", dut.w_ad_oe, 1'b0);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst req_ready", req_ready, 1'b0);
    check("rst rsp_rdata", rsp_rdata, 8'h00);
    exp_tab.delete();
    low_tab.delete();
    last_rdata = 8'h00;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("req_ready after release", req_ready, 1'b1);
    chk_en = 1'b1;
    repeat (3) @(posedge CLK);

    // Recovery: a fresh read completes normally
    txn(1'b0, 1'b0, 20'h80010, 8'h00, 0, 1'b0);
    check("post-reset read", rsp_rdata, 8'h5A);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
